// File: rtl/wb_arb_pkg.sv
// Shared types and sizing helpers for the matrix write-back arbiter.
// Used by matrix_writeback_arbiter (optional duplicate check: WB_DUP_CHECK_EN).
package wb_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WAIT_TX,
        REQUEST,
        HOLD
    } wb_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ELEMENT_SIZE = 8;
    localparam int DEF_SIZE_A       = 32;
    localparam int DEF_SIZE_B       = 32;

    function automatic int wb_total(input int size_a, input int size_b);
        return size_a * size_b;
    endfunction

    // One spare bit so the counter can hold TOTAL itself.
    function automatic int wb_cnt_width(input int total);
        return $clog2(total) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after i_ptr (wrapping) wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = PW'((32'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_writeback_arbiter.sv
// Collects matrix elements from NUM_REQ producers into the matrix store, then hands off to Ethernet.
// Define WB_DUP_CHECK_EN to add a written-address bitmap and the err_dup output.
module matrix_writeback_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_REQ          = DEF_NUM_REQ,
    parameter int MAX_ELEMENT_SIZE = DEF_ELEMENT_SIZE,
    parameter int MAX_SIZE_A       = DEF_SIZE_A,
    parameter int MAX_SIZE_B       = DEF_SIZE_B
) (
    input  logic                                    inter_refclk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ*$clog2(MAX_SIZE_A)-1:0]   req_row,
    input  logic [NUM_REQ*$clog2(MAX_SIZE_B)-1:0]   req_col,
    input  logic [NUM_REQ*MAX_ELEMENT_SIZE-1:0]     req_element,
    output logic                                    valid_data_out,
    output logic [$clog2(MAX_SIZE_A)-1:0]           row_addr,
    output logic [$clog2(MAX_SIZE_B)-1:0]           col_addr,
    output logic [MAX_ELEMENT_SIZE-1:0]             matrix_element,
    input  logic                                    tx_ready,
    input  logic                                    tx_done,
    output logic                                    data_request,
    output logic                                    busy,
    output logic                                    compile_done
`ifdef WB_DUP_CHECK_EN
    ,
    output logic                                    err_dup
`endif
);

    localparam int RW    = $clog2(MAX_SIZE_A);
    localparam int CW    = $clog2(MAX_SIZE_B);
    localparam int EW    = MAX_ELEMENT_SIZE;
    localparam int TOTAL = wb_total(MAX_SIZE_A, MAX_SIZE_B);
    localparam int CNTW  = wb_cnt_width(TOTAL);
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [RW:0]     ROW_LIM  = (RW + 1)'(MAX_SIZE_A);
    localparam logic [CW:0]     COL_LIM  = (CW + 1)'(MAX_SIZE_B);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(TOTAL);

    wb_state_e          r_state, w_next;
    logic [PW-1:0]      r_ptr, w_gidx;
    logic [CNTW-1:0]    r_count;
    logic               r_vdo;
    logic [RW-1:0]      r_row, w_row;
    logic [CW-1:0]      r_col, w_col;
    logic [EW-1:0]      r_elem, w_elem;
    logic [NUM_REQ-1:0] w_req, w_grant;
    logic               w_accept, w_xfer, w_in_range, w_fwd, w_cnt_en;

    assign w_accept = (r_state == COLLECT) && (r_count < CNT_FULL);
    assign w_req    = req_valid & {NUM_REQ{w_accept}};

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_xfer    = |w_grant;

    always_comb begin
        w_gidx = '0;
        w_row  = '0;
        w_col  = '0;
        w_elem = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = PW'(i);
                w_row  = req_row[i*RW +: RW];
                w_col  = req_col[i*CW +: CW];
                w_elem = req_element[i*EW +: EW];
            end
        end
    end

    assign w_in_range = ({1'b0, w_row} < ROW_LIM) && ({1'b0, w_col} < COL_LIM);

`ifdef WB_DUP_CHECK_EN
    localparam int IDXW = $clog2(TOTAL);

    logic [TOTAL-1:0] r_written;
    logic [IDXW-1:0]  w_idx;
    logic             w_dup;
    logic             r_err_dup;

    assign w_idx    = IDXW'(w_row) * IDXW'(MAX_SIZE_B) + IDXW'(w_col);
    assign w_dup    = w_in_range && r_written[w_idx];
    assign w_fwd    = w_xfer && w_in_range && !w_dup;
    assign w_cnt_en = w_xfer && !w_dup;
    assign err_dup  = r_err_dup;

    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_written <= '0;
            r_err_dup <= 1'b0;
        end else begin
            r_err_dup <= w_xfer && w_dup;
            if (r_state == IDLE && start) begin
                r_written <= '0;
            end else if (w_fwd) begin
                r_written[w_idx] <= 1'b1;
            end
        end
    end
`else
    assign w_fwd    = w_xfer && w_in_range;
    assign w_cnt_en = w_xfer;
`endif

    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)                w_next = COLLECT;
            COLLECT: if (r_count == CNT_FULL)  w_next = WAIT_TX;
            WAIT_TX: if (tx_ready)             w_next = REQUEST;
            REQUEST:                           w_next = HOLD;
            HOLD:    if (tx_done)              w_next = IDLE;
            default:                           w_next = IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != IDLE);
        data_request = (r_state == REQUEST);
    end

    // Out-of-range or duplicate transfers still advance ptr; data registers only load on forward.
    always_ff @(posedge inter_refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_vdo   <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_elem  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_count <= '0;
            end else if (w_cnt_en) begin
                r_count <= r_count + 1'b1;
            end
            if (w_xfer) begin
                r_ptr <= (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end
            r_vdo <= w_fwd;
            if (w_fwd) begin
                r_row  <= w_row;
                r_col  <= w_col;
                r_elem <= w_elem;
            end
        end
    end

    assign valid_data_out = r_vdo;
    assign row_addr       = r_row;
    assign col_addr       = r_col;
    assign matrix_element = r_elem;
    assign compile_done   = (r_count == CNT_FULL);

endmodule

// File: tb/tb_matrix_writeback_arbiter.sv
// Randomized bench for matrix_writeback_arbiter against a transaction-level reference model.
// Covers WB_DUP_CHECK_EN when the macro is defined for the build.
module tb_matrix_writeback_arbiter;

    localparam int NR = 4, EW = 8, SA = 32, SB = 32, RW = 5, CW = 5;
    localparam int TOTAL = SA * SB;

    logic              inter_refclk = 1'b0;
    logic              rst_n = 1'b0, start = 1'b0, tx_ready = 1'b0, tx_done = 1'b0;
    logic [NR-1:0]     req_valid = '0, req_ready;
    logic [NR*RW-1:0]  req_row = '0;
    logic [NR*CW-1:0]  req_col = '0;
    logic [NR*EW-1:0]  req_element = '0;
    logic              valid_data_out, data_request, busy, compile_done;
    logic [RW-1:0]     row_addr;
    logic [CW-1:0]     col_addr;
    logic [EW-1:0]     matrix_element;

    // Small instance (5x4 matrix, 2 requesters) so out-of-range rows are representable.
    logic              s_start = 1'b0;
    logic [1:0]        s_req_valid = '0, s_req_ready;
    logic [5:0]        s_req_row = '0;
    logic [3:0]        s_req_col = '0;
    logic [15:0]       s_req_element = '0;
    logic              s_vdo, s_dreq, s_busy, s_cdone;
    logic [2:0]        s_row_addr;
    logic [1:0]        s_col_addr;
    logic [7:0]        s_elem;
`ifdef WB_DUP_CHECK_EN
    logic              err_dup, s_err_dup;
`endif

    matrix_writeback_arbiter u_dut (
        .inter_refclk(inter_refclk), .rst_n(rst_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row),
        .req_col(req_col), .req_element(req_element),
        .valid_data_out(valid_data_out), .row_addr(row_addr), .col_addr(col_addr),
        .matrix_element(matrix_element), .tx_ready(tx_ready), .tx_done(tx_done),
        .data_request(data_request), .busy(busy), .compile_done(compile_done)
`ifdef WB_DUP_CHECK_EN
        , .err_dup(err_dup)
`endif
    );

    matrix_writeback_arbiter #(
        .NUM_REQ(2), .MAX_ELEMENT_SIZE(8), .MAX_SIZE_A(5), .MAX_SIZE_B(4)
    ) u_small (
        .inter_refclk(inter_refclk), .rst_n(rst_n), .start(s_start),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_row(s_req_row),
        .req_col(s_req_col), .req_element(s_req_element),
        .valid_data_out(s_vdo), .row_addr(s_row_addr), .col_addr(s_col_addr),
        .matrix_element(s_elem), .tx_ready(1'b0), .tx_done(1'b0),
        .data_request(s_dreq), .busy(s_busy), .compile_done(s_cdone)
`ifdef WB_DUP_CHECK_EN
        , .err_dup(s_err_dup)
`endif
    );

    always #5 inter_refclk = ~inter_refclk;

    int unsigned n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting, 2 waiting for tx, 3 requesting, 4 holding
    int            m_ph, m_ptr, m_cnt, m_gen, n_dreq;
    bit            m_vdo, m_dup;
    logic [RW-1:0] m_row;
    logic [CW-1:0] m_col;
    logic [EW-1:0] m_elem;
    bit            used [TOTAL];
    logic [NR-1:0] obs_gnt;

    function automatic int exp_grant();
        if (m_ph != 1 || m_cnt >= TOTAL) return -1;
        for (int k = 0; k < NR; k++)
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        return -1;
    endfunction

    function automatic int next_addr();
        while (m_gen < TOTAL && used[(m_gen * 37) % TOTAL]) m_gen++;
        return (m_gen * 37) % TOTAL;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_ptr = 0; m_cnt = 0; m_gen = 0;
        m_vdo = 0; m_dup = 0; m_row = '0; m_col = '0; m_elem = '0;
        foreach (used[i]) used[i] = 0;
    endtask

    task automatic check_outputs();
        chk("valid_data_out", valid_data_out, m_vdo);
        chk("row_addr", row_addr, m_row);
        chk("col_addr", col_addr, m_col);
        chk("matrix_element", matrix_element, m_elem);
        chk("compile_done", compile_done, m_cnt == TOTAL);
        chk("busy", busy, m_ph != 0);
        chk("data_request", data_request, m_ph == 3);
`ifdef WB_DUP_CHECK_EN
        chk("err_dup", err_dup, m_dup);
`endif
    endtask

    // Inputs are already driven; check the grant, predict the edge, then check outputs after it.
    task automatic step();
        int g, cnt0, r, c;
        bit inr, dup;
        #1;
        g = exp_grant();
        obs_gnt = req_ready;
        chk("req_ready", req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
        cnt0 = m_cnt; m_vdo = 0; m_dup = 0;
        if (g >= 0) begin
            r = int'(req_row[g*RW +: RW]);
            c = int'(req_col[g*CW +: CW]);
            inr = (r < SA) && (c < SB);
            dup = 0;
`ifdef WB_DUP_CHECK_EN
            dup = inr && used[r*SB + c];
`endif
            if (inr && !dup) begin
                m_vdo = 1; m_row = RW'(r); m_col = CW'(c);
                m_elem = req_element[g*EW +: EW];
                used[r*SB + c] = 1;
            end
            if (!dup) m_cnt++;
            m_dup = dup;
            m_ptr = (g + 1) % NR;
        end
        case (m_ph)
            0: if (start) begin
                   m_ph = 1; m_cnt = 0; m_gen = 0;
                   foreach (used[i]) used[i] = 0;
               end
            1: if (cnt0 == TOTAL) m_ph = 2;
            2: if (tx_ready) m_ph = 3;
            3: m_ph = 4;
            4: if (tx_done) m_ph = 0;
            default: ;
        endcase
        @(posedge inter_refclk);
        #1;
        check_outputs();
        if (data_request) n_dreq++;
    endtask

    task automatic do_reset();
        @(negedge inter_refclk);
        rst_n = 0; start = 0; tx_ready = 0; tx_done = 0; req_valid = '0;
        s_start = 0; s_req_valid = '0;
        model_reset();
        #1;
        check_outputs();
        chk("req_ready_in_reset", req_ready, 0);
        @(negedge inter_refclk);
        rst_n = 1;
    endtask

    task automatic drive_rand(input bit allow_ctl);
        int g, a;
        req_valid = NR'($urandom);
        for (int i = 0; i < NR; i++) begin
            req_row[i*RW +: RW]     = RW'($urandom);
            req_col[i*CW +: CW]     = CW'($urandom);
            req_element[i*EW +: EW] = EW'($urandom);
        end
        g = exp_grant();
        if (g >= 0) begin
            a = next_addr();
            req_row[g*RW +: RW] = RW'(a / SB);
            req_col[g*CW +: CW] = CW'(a % SB);
        end
        start   = allow_ctl && ($urandom_range(0, 40) == 0);
        tx_done = allow_ctl && ($urandom_range(0, 40) == 0);
    endtask

    task automatic begin_matrix();
        req_valid = '0; start = 1; tx_done = 0;
        step();
        start = 0;
    endtask

    task automatic collect(input int target, input bit txr);
        int budget = 8 * TOTAL;
        while (m_cnt < target && budget > 0) begin
            drive_rand(1'b1);
            tx_ready = txr;
            step();
            budget--;
        end
        chk("collect_within_budget", budget > 0, 1);
        start = 0; tx_done = 0;
    endtask

    task automatic finish_matrix(input int wait_cycles);
        n_dreq = 0;
        for (int k = 0; k < wait_cycles; k++) begin
            drive_rand(1'b0); start = 1'($urandom_range(0, 1)); tx_ready = 0;
            step();
        end
        tx_ready = 1;
        for (int k = 0; k < 8 && m_ph != 4; k++) begin
            drive_rand(1'b0); start = 1'($urandom_range(0, 1));
            step();
        end
        tx_ready = 0;
        for (int k = 0; k < 3; k++) begin
            drive_rand(1'b0); start = 1'($urandom_range(0, 1));
            step();
        end
        start = 0; tx_done = 1; step();
        tx_done = 0; step();
        chk("data_request_cycles", n_dreq, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single requester 2 at (3,5) with 0xA7
        begin_matrix();
        req_valid = 4'b0100;
        req_row[2*RW +: RW] = 5'd3; req_col[2*CW +: CW] = 5'd5; req_element[2*EW +: EW] = 8'hA7;
        step();
        chk("dir_req_ready", obs_gnt, 4'b0100);
        chk("dir_vdo", valid_data_out, 1);
        chk("dir_row", row_addr, 3);
        chk("dir_col", col_addr, 5);
        chk("dir_elem", matrix_element, 8'hA7);
        req_valid = '0; step();
        chk("dir_vdo_drop", valid_data_out, 0);

        // All valid from ptr=0 -> 0,1,2,3,0
        do_reset();
        begin_matrix();
        for (int k = 0; k < 5; k++) begin
            int a;
            a = next_addr();
            req_valid = '1;
            for (int i = 0; i < NR; i++) begin
                req_row[i*RW +: RW] = RW'(a / SB); req_col[i*CW +: CW] = CW'(a % SB);
                req_element[i*EW +: EW] = EW'($urandom);
            end
            step();
            chk("rr_order", obs_gnt, 4'b0001 << (k % 4));
        end
        req_valid = '0;

        // Full matrix with delayed tx_ready, then one with tx_ready already high
        collect(TOTAL, 1'b0);
        finish_matrix(7);
        begin_matrix();
        collect(TOTAL, 1'b1);
        finish_matrix(0);

        // Reset after 500 transfers discards progress
        begin_matrix();
        collect(500, 1'b0);
        do_reset();
        begin_matrix();
        collect(TOTAL - 1, 1'b0);
        chk("no_early_compile_done", compile_done, 0);
        collect(TOTAL, 1'b0);
        chk("compile_done_after_full", compile_done, 1);
        finish_matrix(3);

`ifdef WB_DUP_CHECK_EN
        // Address (1,1) twice from requester 1
        do_reset();
        begin_matrix();
        for (int k = 0; k < 2; k++) begin
            req_valid = 4'b0010;
            req_row[RW +: RW] = 5'd1; req_col[CW +: CW] = 5'd1; req_element[EW +: EW] = EW'(k + 1);
            step();
            chk("dup_granted", obs_gnt, 4'b0010);
            chk("dup_vdo", valid_data_out, k == 0);
            chk("dup_err", err_dup, k == 1);
        end
        req_valid = '0; step();
        chk("dup_err_single_pulse", err_dup, 0);
        collect(TOTAL, 1'b0);
        finish_matrix(2);
`endif

        // Out-of-range row on the 5x4 instance: granted, counted, not forwarded
        do_reset();
        s_start = 1; @(posedge inter_refclk); #1; s_start = 0;
        s_req_valid = 2'b01; s_req_row[2:0] = 3'd6; s_req_col[1:0] = 2'd1; s_req_element[7:0] = 8'h5C;
        #1;
        chk("oor_ready", s_req_ready, 2'b01);
        @(posedge inter_refclk); #1;
        chk("oor_vdo", s_vdo, 0);
        chk("oor_row_held", s_row_addr, 0);
        for (int k = 0; k < 19; k++) begin
            s_req_row[2:0] = 3'(k / 4); s_req_col[1:0] = 2'(k % 4); s_req_element[7:0] = 8'(k);
            #1;
            chk("small_ready", s_req_ready, 2'b01);
            @(posedge inter_refclk); #1;
            chk("small_vdo", s_vdo, 1);
            chk("small_row", s_row_addr, k / 4);
            chk("small_elem", s_elem, k);
            chk("small_compile_done", s_cdone, k == 18);
        end
        #1;
        chk("small_full_no_grant", s_req_ready, 0);
        s_req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
